pipe_latch: RTL
===============

PIPE_LATCH -- requirements
Module: pipe_latch

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the payload width in bits; legal range 1..256.
REQ-002 Parameter SKID_EN, default 1, SHALL select the storage depth: 1 = two entries (main + skid), 0 = single register with combinational ready pass-through.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 CLK  input  1  rising-edge clock; sole clock of the block.
REQ-005 nRST  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  discard all held entries.
REQ-007 freeze  input  1  hold contents; block both handshakes.
REQ-008 in_valid  input  1  upstream has data.
REQ-009 in_ready  output  1  block can accept data.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 out_valid  output  1  block presents data.
REQ-012 out_ready  input  1  downstream can accept data.
REQ-013 out_data  output  DATA_W  payload of the oldest entry.
REQ-014 count  output  2  number of held entries, 0..2.
REQ-015 stall_cycles  output  CNT_W  saturating count of stalled cycles.

Function
REQ-016 accept = in_valid & in_ready; drain = out_valid & out_ready; both SHALL be evaluated in the same cycle.
REQ-017 State SHALL be EMPTY, ONE or TWO; TWO SHALL be unreachable when SKID_EN=0.
REQ-018 out_valid SHALL be 1 iff state != EMPTY and freeze=0.
REQ-019 out_data SHALL equal the main register, i.e. the oldest entry; its value while out_valid=0 SHALL NOT be checked.
REQ-020 SKID_EN=1: in_ready SHALL be 1 iff state != TWO and freeze=0, decoded from state only, with no combinational path from out_ready.
REQ-021 SKID_EN=0: in_ready SHALL be (state==EMPTY | out_ready) & ~freeze.
REQ-022 EMPTY: accept -> ONE; main <= in_data.
REQ-023 ONE: accept & drain -> ONE, main <= in_data; drain only -> EMPTY; accept only -> TWO (SKID_EN=1), skid <= in_data; neither -> ONE.
REQ-024 TWO: drain -> ONE, main <= skid; no drain -> TWO; accept is impossible.
REQ-025 Entries SHALL leave in strict arrival order; no entry SHALL be lost or duplicated.
REQ-026 Latency SHALL be 1 cycle: data accepted in cycle N SHALL be on out_data with out_valid=1 in cycle N+1 when the block was empty.
REQ-027 flush=1 SHALL move state to EMPTY at the next edge, discarding held entries and any same-cycle accept; flush SHALL take priority over freeze and all handshakes.
REQ-028 During flush, drain in the same cycle SHALL still count as delivered downstream; the upstream SHALL treat the same-cycle accept as dropped.
REQ-029 freeze=1 (no flush) SHALL hold state and data unchanged.
REQ-030 count SHALL be 0/1/2 for EMPTY/ONE/TWO.
REQ-031 stall_cycles SHALL increment by 1 on every cycle with state != EMPTY and no drain, including frozen cycles; it SHALL saturate at 2^CNT_W-1 and SHALL NOT be cleared by flush.

Reset
REQ-032 nRST=0 at a rising edge SHALL set state EMPTY, main and skid to 0, and stall_cycles to 0.
REQ-033 While nRST=0, in_ready and out_valid SHALL be 0; reset SHALL override flush, freeze and any handshake in progress.
REQ-034 The first accept SHALL be possible in the first cycle with nRST=1.

Verification
REQ-035 SKID_EN=1, DATA_W=32: push 0xA, 0xB with out_ready=0 -> count=2, in_ready=0, out_data=0xA; raise out_ready for 2 cycles -> 0xA then 0xB out, count=0.
REQ-036 Streaming: in_valid=out_ready=1 for 100 cycles with an incrementing pattern -> identical sequence out, 1-cycle latency, stall_cycles unchanged.
REQ-037 Full with 0x1,0x2; assert flush with in_valid=1, in_data=0x3 -> next cycle count=0, out_valid=0, 0x3 never emitted, stall_cycles held.
REQ-038 freeze=1 for 5 cycles while count=1 -> out_valid=0, in_ready=0, data held, stall_cycles +5; release -> held entry delivered.
REQ-039 CNT_W=4, out_ready=0 with one entry held for 20 cycles -> stall_cycles saturates at 15.
REQ-040 SKID_EN=0: count=1, out_ready=1, in_valid=1 -> in_ready=1 the same cycle, replacement in one edge; nRST=0 mid-stream -> count=0, stall_cycles=0 the next cycle.

Source files
------------

// File: rtl/pipe_latch_if.sv
// Valid/ready handshake bundle for pipe_latch: the upstream (in_*) and downstream (out_*) channels.
// The block itself takes the slave view; whoever drives and consumes it takes the master view.
interface pipe_latch_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_latch.sv
// Pipeline latch: one-cycle register slice with an optional skid entry, flush/freeze control
// and a saturating counter of cycles in which held data could not leave.
module pipe_latch #(
  parameter int DATA_W  = 64,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             freeze,
  pipe_latch_if.slave      bus,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_ready_w, out_valid_w, accept, drain;

  // With the skid entry, in_ready depends on state only, which breaks the out_ready -> in_ready path.
  always_comb begin
    out_valid_w = nRST && !freeze && (state_q != ST_EMPTY);
    in_ready_w  = 1'b0;
    if (nRST && !freeze) begin
      if (SKID_EN) in_ready_w = (state_q != ST_TWO);
      else         in_ready_w = (state_q == ST_EMPTY) || bus.out_ready;
    end
    accept = bus.in_valid && in_ready_w;
    drain  = out_valid_w && bus.out_ready;
  end

  // Freeze needs no branch of its own: it forces accept and drain low, so every state holds.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if ((state_q != ST_EMPTY) && !drain && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = bus.in_data;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = bus.in_data;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end else if (accept && SKID_EN) begin
            state_d = ST_TWO;
            skid_d  = bus.in_data;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values, whatever the
    // statement order.
    if (!nRST) begin
      state_q <= ST_EMPTY;
      // NOTE: payload registers are cleared as well, so out_data is a known value right after
      // reset.
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = main_q;
  assign count         = state_q;
  assign stall_cycles  = stall_q;

endmodule
